// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared constants and address helpers for the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MISS_RD = 2'd1;
    localparam logic [1:0] ST_WR_THRU = 2'd2;

    // RV32 load/store funct3 encodings (stores reuse B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Set index of a byte address: the bits just above the word offset.
    // Addresses are handled as 32 bits, so ADDR_WIDTH may not exceed 32.
    function automatic logic [31:0] line_index(input logic [31:0] addr,
                                               input int unsigned idx_bits);
        return (addr >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Tag of a byte address: everything above the set index.
    function automatic logic [31:0] line_tag(input logic [31:0] addr,
                                             input int unsigned idx_bits);
        return addr >> (2 + idx_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_align.sv
`default_nettype none
// ============================================================================
// Module      : dcache_align
// Description : Byte-lane alignment for stores (strobe + replicated lanes)
//               and byte/half selection with sign/zero extension for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_align
    import dcache_pkg::*;
(
    input  logic [2:0]  i_ctrl,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wlane,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    // Halfword select ignores addr[0]; word accesses ignore both low bits
    assign w_byte     = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half     = i_rword[{i_addr_lo[1], 4'b0000} +: 16];
    assign w_unsigned = i_ctrl[2];

    // Width decode: strobe, lane replication and load extension
    always_comb begin
        o_wstrb = 4'b1111;
        o_wlane = i_wdata;
        o_rdata = i_rword;
        case (i_ctrl[1:0])
            F3_B[1:0]: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wlane = {4{i_wdata[7:0]}};
                o_rdata = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            F3_H[1:0]: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wlane = {2{i_wdata[15:0]}};
                o_rdata = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Set-associative (1/2-way), write-through, no-write-allocate
//               data cache with one-word lines, flop storage, zero-latency
//               read hits and saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [2:0]             cpu_ctrl,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    output logic [DATA_WIDTH-1:0]  cpu_rdata,
    output logic                   cpu_stall,
    input  logic                   flush,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-3:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [3:0]             mem_wstrb,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

    // Storage
    logic                  r_valid [WAYS][SETS];
    logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] r_data  [WAYS][SETS];

    logic [1:0]             r_state;
    logic                   r_victim;
    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [ADDR_WIDTH-3:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic [3:0]             r_mem_wstrb;
    logic [COUNT_WIDTH-1:0] r_hit_cnt;
    logic [COUNT_WIDTH-1:0] r_miss_cnt;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [WAYS-1:0]       w_hit_way;
    logic                  w_hit_sel;
    logic [DATA_WIDTH-1:0] w_hit_word;
    logic                  w_victim;
    logic                  w_lru_cur;
    logic                  w_hit;
    logic                  w_idle;
    logic                  w_ld_hit;
    logic                  w_ld_miss;
    logic                  w_st;
    logic                  w_st_hit;
    logic                  w_fill;
    logic                  w_lru_we;
    logic                  w_lru_val;
    logic [DATA_WIDTH-1:0] w_rword;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_wlane;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_idx = IDX_W'(line_index(32'(cpu_addr), IDX_W));
    assign w_tag = TAG_W'(line_tag(32'(cpu_addr), IDX_W));

    // Tag compare across ways and victim choice (first invalid, else LRU)
    always_comb begin
        w_hit_way  = '0;
        w_hit_sel  = 1'b0;
        w_hit_word = '0;
        w_victim   = w_lru_cur;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit_way[w] = 1'b1;
                w_hit_sel    = 1'(w);
                w_hit_word   = r_data[w][w_idx];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_victim = 1'(w);
            end
        end
        // A flush in the same cycle empties the set before the fill lands
        if (flush) begin
            w_victim = 1'b0;
        end
    end

    // A flush coinciding with a request makes the lookup see empty storage
    assign w_hit     = (|w_hit_way) && !flush;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_ld_hit  = w_idle && cpu_req && !cpu_we && w_hit;
    assign w_ld_miss = w_idle && cpu_req && !cpu_we && !w_hit;
    assign w_st      = w_idle && cpu_req && cpu_we;
    assign w_st_hit  = w_st && w_hit;
    assign w_fill    = (r_state == ST_MISS_RD) && mem_ack;

    assign w_lru_we  = w_ld_hit || w_fill;
    assign w_lru_val = w_ld_hit ? ~w_hit_sel : ~r_victim;

    // The core holds its inputs during a stall, so the fill reuses cpu_addr
    assign w_rword = (r_state == ST_MISS_RD) ? mem_rdata : w_hit_word;

    dcache_align u_align (
        .i_ctrl    (cpu_ctrl),
        .i_addr_lo (cpu_addr[1:0]),
        .i_wdata   (cpu_wdata),
        .i_rword   (w_rword),
        .o_wstrb   (w_wstrb),
        .o_wlane   (w_wlane),
        .o_rdata   (w_ext)
    );

    assign cpu_stall  = w_idle ? (cpu_req && !w_ld_hit) : !mem_ack;
    assign cpu_rdata  = (w_ld_hit || w_fill) ? w_ext : '0;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    generate
        if (WAYS == 2) begin : g_lru
            logic r_lru [SETS];

            // One LRU bit per set, naming the way to evict next
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        r_lru[s] <= 1'b0;
                    end
                end else if (w_lru_we) begin
                    r_lru[w_idx] <= w_lru_val;
                end
            end

            assign w_lru_cur = r_lru[w_idx];
        end else begin : g_no_lru
            assign w_lru_cur = 1'b0;
        end
    endgenerate

    // Valid bits: reset/flush clear everything, a completed fill sets one
    always_ff @(posedge clk) begin
        if (!rst || (w_idle && flush)) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                end
            end
        end else if (w_fill) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_victim == 1'(w)) begin
                    r_valid[w][w_idx] <= 1'b1;
                end
            end
        end
    end

    // Tag/data: line fill on read ack, byte merge on an accepted store hit
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (w_fill && (r_victim == 1'(w))) begin
                r_tag[w][w_idx]  <= w_tag;
                r_data[w][w_idx] <= mem_rdata;
            end else if (w_st_hit && w_hit_way[w]) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wstrb[b]) begin
                        r_data[w][w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                    end
                end
            end
        end
    end

    // Controller FSM, registered memory request and saturating counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_victim    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'b0000;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_st) begin
                        r_state     <= ST_WR_THRU;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= cpu_addr[ADDR_WIDTH-1:2];
                        r_mem_wdata <= w_wlane;
                        r_mem_wstrb <= w_wstrb;
                    end else if (w_ld_miss) begin
                        r_state     <= ST_MISS_RD;
                        r_victim    <= w_victim;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= cpu_addr[ADDR_WIDTH-1:2];
                        r_mem_wstrb <= 4'b0000;
                    end
                end
                ST_MISS_RD, ST_WR_THRU: begin
                    if (mem_ack) begin
                        r_state     <= ST_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if ((w_ld_hit || w_st_hit) && (r_hit_cnt != {COUNT_WIDTH{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_ld_miss && (r_miss_cnt != {COUNT_WIDTH{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Self-checking bench for data_cache: directed scenarios plus
//               randomized traffic against a recency-list cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we, flush, mem_ack;
    logic [2:0]  cpu_ctrl;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic [31:0] cpu_rdata, mem_wdata;
    logic        cpu_stall, mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [CW-1:0] hit_count, miss_count;

    data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(16), .WAYS(2), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ctrl(cpu_ctrl),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each set is a recency list of at most two lines, index 0 most recent.
    int unsigned m_cnt  [16];
    logic [29:0] m_line [16][2];
    logic [31:0] m_dat  [16][2];
    int unsigned m_hits, m_misses;
    logic [31:0] bmem [logic [29:0]];

    int n_pass = 0;
    int n_total = 0;

    // Expectations for the current cycle, consumed by the compare process
    logic        e_chk = 1'b0, e_rst = 1'b0, e_stall, e_chk_rd, e_mreq, e_mwe, e_cap0;
    logic [31:0] e_rdata, e_mwdata;
    logic [29:0] e_maddr;
    logic [3:0]  e_wstrb;
    int unsigned e_hit, e_miss;
    logic [31:0] cap_rdata;
    logic        cap_stall0;

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (bmem.exists(wa)) return bmem[wa];
        return {wa, 2'b01} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] c,
                                           input logic [1:0] a);
        logic [31:0] v;
        if (c[1:0] == 2'b00) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!c[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (c[1:0] == 2'b01) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!c[2] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] st_strb(input logic [2:0] c, input logic [1:0] a);
        if (c[1:0] == 2'b00) return 4'b0001 << a;
        if (c[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] st_lane(input logic [31:0] d, input logic [2:0] c,
                                            input logic [1:0] a);
        if (c[1:0] == 2'b00) return 32'(d[7:0]) << (8 * a);
        if (c[1:0] == 2'b01) return 32'(d[15:0]) << (16 * a[1]);
        return d;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 16; s++) m_cnt[s] = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (e_chk) begin
            chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
            if (e_chk_rd) begin
                chk("cpu_rdata", cpu_rdata, e_rdata);
                cap_rdata = cpu_rdata;
            end
            chk("mem_req", 32'(mem_req), 32'(e_mreq));
            if (e_mreq) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
                chk("mem_we", 32'(mem_we), 32'(e_mwe));
                if (e_mwe) begin
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
                    chk("mem_wdata", mem_wdata & byte_mask(e_wstrb), e_mwdata & byte_mask(e_wstrb));
                end
            end
            if (e_rst) begin
                chk("rst mem_we", 32'(mem_we), 32'd0);
                chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
                chk("rst mem_addr", 32'(mem_addr), 32'd0);
                chk("rst mem_wdata", mem_wdata, 32'd0);
            end
            chk("hit_count", 32'(hit_count), e_hit);
            chk("miss_count", 32'(miss_count), e_miss);
            if (e_cap0) cap_stall0 = cpu_stall;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input bit fl, input bit spur_ack);
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; flush = fl;
        mem_ack = spur_ack; mem_rdata = $urandom;
        e_chk = 1'b1; e_rst = 1'b0; e_stall = 1'b0; e_chk_rd = 1'b1; e_rdata = '0;
        e_mreq = 1'b0; e_mwe = 1'b0; e_cap0 = 1'b0; e_hit = m_hits; e_miss = m_misses;
        next_cycle();
        if (fl) model_clear();
        flush = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic access(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wd, input bit fl, input int lat, input int abort_at);
        logic [29:0] wa;
        int s, way;
        logic [3:0]  strb;
        logic [31:0] lane;
        wa = addr[31:2];
        s = int'(wa[3:0]);
        strb = st_strb(ctrl, addr[1:0]);
        lane = st_lane(wd, ctrl, addr[1:0]);
        if (fl) model_clear();
        way = -1;
        for (int i = 0; i < int'(m_cnt[s]); i++) if (m_line[s][i] == wa) way = i;

        rst = 1'b1; cpu_req = 1'b1; cpu_we = we; cpu_ctrl = ctrl; cpu_addr = addr;
        cpu_wdata = wd; flush = fl; mem_ack = 1'b0; mem_rdata = $urandom;
        e_chk = 1'b1; e_rst = 1'b0; e_hit = m_hits; e_miss = m_misses;
        e_mreq = 1'b0; e_mwe = 1'b0; e_cap0 = 1'b1;

        if (!we && way >= 0) begin
            e_stall = 1'b0; e_chk_rd = 1'b1;
            e_rdata = ld_ext(m_dat[s][way], ctrl, addr[1:0]);
            next_cycle();
            e_cap0 = 1'b0; flush = 1'b0; cpu_req = 1'b0;
            if (way == 1) begin
                m_line[s][1] = m_line[s][0]; m_line[s][0] = wa;
                lane = m_dat[s][1]; m_dat[s][1] = m_dat[s][0]; m_dat[s][0] = lane;
            end
            m_hits = sat(m_hits);
            return;
        end

        e_stall = 1'b1; e_chk_rd = 1'b0;
        next_cycle();
        e_cap0 = 1'b0; flush = 1'b0;
        if (we && way >= 0) begin
            m_dat[s][way] = (m_dat[s][way] & ~byte_mask(strb)) | (lane & byte_mask(strb));
            m_hits = sat(m_hits);
        end
        if (!we) m_misses = sat(m_misses);
        e_mreq = 1'b1; e_maddr = wa; e_mwe = we; e_wstrb = strb; e_mwdata = lane;
        e_hit = m_hits; e_miss = m_misses;

        for (int c = 1; c <= lat; c++) begin
            if (c == abort_at) begin
                rst = 1'b0; e_chk = 1'b0;
                next_cycle();
                rst = 1'b1; cpu_req = 1'b0;
                model_clear(); m_hits = 0; m_misses = 0;
                return;
            end
            if (c == lat) begin
                mem_ack = 1'b1;
                mem_rdata = we ? $urandom : mem_rd(wa);
                e_stall = 1'b0;
                if (!we) begin
                    e_chk_rd = 1'b1;
                    e_rdata = ld_ext(mem_rdata, ctrl, addr[1:0]);
                end
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom; e_stall = 1'b1;
            end
            next_cycle();
        end
        mem_ack = 1'b0; e_chk_rd = 1'b0; cpu_req = 1'b0;
        if (we) begin
            bmem[wa] = (mem_rd(wa) & ~byte_mask(strb)) | (lane & byte_mask(strb));
        end else begin
            m_line[s][1] = m_line[s][0]; m_dat[s][1] = m_dat[s][0];
            m_line[s][0] = wa; m_dat[s][0] = mem_rd(wa);
            if (m_cnt[s] < 2) m_cnt[s]++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ld_ops [5];
        logic [2:0] op;
        logic [31:0] a;
        int lat, ab;
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        model_clear(); m_hits = 0; m_misses = 0;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_ctrl = 3'b000; cpu_addr = '0;
        cpu_wdata = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        next_cycle();
        next_cycle();
        // Reset state, checked while reset is still applied
        e_chk = 1'b1; e_rst = 1'b1; e_stall = 1'b0; e_chk_rd = 1'b1; e_rdata = '0;
        e_mreq = 1'b0; e_mwe = 1'b0; e_cap0 = 1'b0; e_hit = 0; e_miss = 0;
        next_cycle();
        e_rst = 1'b0;
        idle_cycle(1'b0, 1'b0);

        // Directed: first miss, then hits with every load width
        bmem[30'h40] = 32'hDEADBEEF;
        access(1'b0, 3'b010, 32'h100, 0, 1'b0, 3, 0);
        chk("miss stall0", 32'(cap_stall0), 32'd1);
        chk("miss data", cap_rdata, 32'hDEADBEEF);
        chk("miss_count lit", 32'(miss_count), 32'd1);
        access(1'b0, 3'b010, 32'h100, 0, 1'b0, 1, 0);
        chk("rehit stall0", 32'(cap_stall0), 32'd0);
        chk("hit_count lit", 32'(hit_count), 32'd1);
        access(1'b0, 3'b000, 32'h103, 0, 1'b0, 1, 0);
        chk("LB 103", cap_rdata, 32'hFFFFFFDE);
        access(1'b0, 3'b100, 32'h103, 0, 1'b0, 1, 0);
        chk("LBU 103", cap_rdata, 32'h000000DE);
        access(1'b0, 3'b001, 32'h102, 0, 1'b0, 1, 0);
        chk("LH 102", cap_rdata, 32'hFFFFDEAD);
        access(1'b0, 3'b101, 32'h100, 0, 1'b0, 1, 0);
        chk("LHU 100", cap_rdata, 32'h0000BEEF);
        chk("LHU hit", 32'(cap_stall0), 32'd0);

        // Store hit merge, then store miss that does not allocate
        access(1'b1, 3'b000, 32'h101, 32'h55, 1'b0, 2, 0);
        chk("SB stall0", 32'(cap_stall0), 32'd1);
        access(1'b0, 3'b010, 32'h100, 0, 1'b0, 1, 0);
        chk("merged word", cap_rdata, 32'hDEAD55EF);
        chk("merged hit", 32'(cap_stall0), 32'd0);
        access(1'b1, 3'b010, 32'h200, 32'h12345678, 1'b0, 1, 0);
        access(1'b0, 3'b010, 32'h200, 0, 1'b0, 2, 0);
        chk("SW no-alloc miss", 32'(cap_stall0), 32'd1);
        chk("SW readback", cap_rdata, 32'h12345678);

        // LRU eviction within set 0
        idle_cycle(1'b1, 1'b0);
        access(1'b0, 3'b010, 32'h000, 0, 1'b0, 1, 0);
        access(1'b0, 3'b010, 32'h040, 0, 1'b0, 1, 0);
        access(1'b0, 3'b010, 32'h000, 0, 1'b0, 1, 0);
        access(1'b0, 3'b010, 32'h080, 0, 1'b0, 2, 0);
        access(1'b0, 3'b010, 32'h000, 0, 1'b0, 1, 0);
        chk("keep 000", 32'(cap_stall0), 32'd0);
        access(1'b0, 3'b010, 32'h040, 0, 1'b0, 1, 0);
        chk("evict 040", 32'(cap_stall0), 32'd1);

        // Flush together with a load of a cached line
        access(1'b0, 3'b010, 32'h100, 0, 1'b1, 2, 0);
        chk("flush+LW miss", 32'(cap_stall0), 32'd1);
        access(1'b0, 3'b010, 32'h000, 0, 1'b0, 1, 0);
        chk("flushed 000", 32'(cap_stall0), 32'd1);

        // Reset two cycles into a miss
        access(1'b0, 3'b010, 32'h300, 0, 1'b0, 5, 2);
        idle_cycle(1'b0, 1'b0);
        chk("post-rst miss_count", 32'(miss_count), 32'd0);
        access(1'b0, 3'b010, 32'h100, 0, 1'b0, 1, 0);
        chk("post-rst miss", 32'(cap_stall0), 32'd1);

        // Hit counter saturation
        for (int i = 0; i < 20; i++) access(1'b0, 3'b010, 32'h100, 0, 1'b0, 1, 0);
        chk("hit saturate", 32'(hit_count), 32'hF);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            end else begin
                a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                if ($urandom_range(0, 15) == 0) a = a | 32'h0400_0000;
                lat = $urandom_range(1, 4);
                ab = (lat > 1 && $urandom_range(0, 29) == 0) ? $urandom_range(1, lat - 1) : 0;
                if ($urandom_range(0, 2) == 0) begin
                    op = 3'($urandom_range(0, 2));
                    access(1'b1, op, a, $urandom, $urandom_range(0, 24) == 0, lat, ab);
                end else begin
                    op = ld_ops[$urandom_range(0, 4)];
                    access(1'b0, op, a, 0, $urandom_range(0, 24) == 0, lat, ab);
                end
            end
        end
        idle_cycle(1'b0, 1'b0);
        e_chk = 1'b0;
        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
